sprite_blitter: RTL and testbench

- Upstream controller and downstream consumer of the sprite memory block. It drives MemSel/Address into the sprite memory, samples that block's Width/Height/AnimSteps and its 9-bit DataOut colour.
- For each draw request it emits one plot strobe per sprite pixel, with screen X/Y, toward the VGA framebuffer writer.
- One draw runs at a time. Throughput is one pixel per clock.

---
 rtl/sprite_pkg.sv | 33 +++
 rtl/sprite_addr_gen.sv | 83 ++++++++
 rtl/sprite_blitter.sv | 183 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared constants for the sprite blitter: FSM state encoding,
//             screen size defaults, colour/address widths, colour key and a
//             helper that picks the effective animation frame.
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

   localparam int COLOUR_W = 9;
   localparam int ADDR_W   = 12;

   localparam int SCREEN_W_DEFAULT = 160;
   localparam int SCREEN_H_DEFAULT = 120;

   localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR_DEFAULT = 9'h1C7;

   // Blitter FSM encoding
   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_SETUP = 3'd1;
   localparam logic [2:0] c_RUN   = 3'd2;
   localparam logic [2:0] c_DRAIN = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   // An out-of-range frame request falls back to frame 0.
   function automatic logic [2:0] effFrame(input logic [2:0] frame,
                                           input logic [2:0] animSteps);
      return (frame <= animSteps) ? frame : 3'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_addr_gen
//  Purpose  : Column/row counters and word address generator for one sprite
//             draw. Computes the frame base address on load, then walks the
//             sprite row-major, one word per advance.
//  Ports    : Clock, Resetn (sync, active-low)
//             load      - capture geometry, compute base, clear counters
//             advance   - step to the next pixel (ignored on the last pixel)
//             frame, animSteps, width, height - sprite memory geometry
//             address   - pixel word address toward sprite memory
//             col, row  - coordinates of the pixel currently addressed
//             lastPixel - current pixel is the final one of the sprite
//             empty     - live geometry has zero width or height
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_addr_gen
   import sprite_pkg::*;
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              load,
   input  logic              advance,
   input  logic [2:0]        frame,
   input  logic [2:0]        animSteps,
   input  logic [4:0]        width,
   input  logic [4:0]        height,
   output logic [ADDR_W-1:0] address,
   output logic [4:0]        col,
   output logic [4:0]        row,
   output logic              lastPixel,
   output logic              empty
);

   logic [4:0]        r_width;
   logic [4:0]        r_height;
   logic [4:0]        r_col;
   logic [4:0]        r_row;
   logic [ADDR_W-1:0] r_address;

   logic [2:0]        w_frame;
   logic [ADDR_W-1:0] w_base;

   assign w_frame = effFrame(frame, animSteps);

   // Multiplying at ADDR_W bits gives the required truncation for free.
   assign w_base = {{(ADDR_W-3){1'b0}}, w_frame}
                 * {{(ADDR_W-5){1'b0}}, width}
                 * {{(ADDR_W-5){1'b0}}, height};

   assign empty     = (width == 5'd0) || (height == 5'd0);
   assign lastPixel = (r_col == r_width - 5'd1) && (r_row == r_height - 5'd1);

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_width   <= '0;
         r_height  <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_address <= '0;
      end else if (load) begin
         r_width   <= width;
         r_height  <= height;
         r_col     <= '0;
         r_row     <= '0;
         r_address <= w_base;
      end else if (advance && !lastPixel) begin
         r_address <= r_address + 1'b1;
         if (r_col == r_width - 5'd1) begin
            r_col <= '0;
            r_row <= r_row + 5'd1;
         end else begin
            r_col <= r_col + 5'd1;
         end
      end
   end

   assign address = r_address;
   assign col     = r_col;
   assign row     = r_row;

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter
//  Purpose  : Reads a sprite out of sprite memory and emits one plot strobe
//             per pixel (one per clock) toward the VGA framebuffer writer,
//             with off-screen clipping.
//  Ports    : Clock, Resetn (sync, active-low)
//             Start, SpriteId, Frame, PosX, PosY      - draw request
//             MemSel, Address                         - to sprite memory
//             Width, Height, AnimSteps, DataOut       - from sprite memory
//             PlotX, PlotY, Colour, Plot              - to framebuffer
//             Busy, Done                              - status
//  Options  : SPRITE_BLITTER_TRANSPARENCY_EN - when defined, pixels whose
//             colour equals TRANSPARENT_COLOUR are not plotted.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_blitter
   import sprite_pkg::*;
#(
   parameter int                  SCREEN_W           = SCREEN_W_DEFAULT,
   parameter int                  SCREEN_H           = SCREEN_H_DEFAULT,
   parameter int                  XW                 = 8,
   parameter int                  YW                 = 7,
   parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = TRANSPARENT_COLOUR_DEFAULT
)(
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Start,
   input  logic [2:0]          SpriteId,
   input  logic [2:0]          Frame,
   input  logic [XW-1:0]       PosX,
   input  logic [YW-1:0]       PosY,
   output logic [2:0]          MemSel,
   output logic [ADDR_W-1:0]   Address,
   input  logic [4:0]          Width,
   input  logic [4:0]          Height,
   input  logic [2:0]          AnimSteps,
   input  logic [COLOUR_W-1:0] DataOut,
   output logic [XW-1:0]       PlotX,
   output logic [YW-1:0]       PlotY,
   output logic [COLOUR_W-1:0] Colour,
   output logic                Plot,
   output logic                Busy,
   output logic                Done
);

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
   localparam bit c_KEY_EN = 1'b1;
`else
   localparam bit c_KEY_EN = 1'b0;
`endif

   localparam logic [XW:0] c_SCREEN_W = (XW+1)'(SCREEN_W);
   localparam logic [YW:0] c_SCREEN_H = (YW+1)'(SCREEN_H);

   // Control / request registers
   logic [2:0]    r_state;
   logic [2:0]    r_memSel;
   logic [2:0]    r_frame;
   logic [XW-1:0] r_posX;
   logic [YW-1:0] r_posY;

   // Address generator interface
   logic          w_load;
   logic          w_advance;
   logic [4:0]    w_col;
   logic [4:0]    w_row;
   logic          w_lastPixel;
   logic          w_empty;

   // Stage 1: address has been consumed by memory, DataOut valid this cycle
   logic          r_valid1;
   logic [4:0]    r_col1;
   logic [4:0]    r_row1;

   // Stage 2: framebuffer outputs
   logic [XW-1:0]       r_plotX;
   logic [YW-1:0]       r_plotY;
   logic [COLOUR_W-1:0] r_colour;
   logic                r_plot;

   logic [XW:0]   w_sumX;
   logic [YW:0]   w_sumY;
   logic          w_onScreen;
   logic          w_transparent;

   assign w_load    = (r_state == c_SETUP);
   assign w_advance = (r_state == c_RUN);

   sprite_addr_gen u_addrGen (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .load      (w_load),
      .advance   (w_advance),
      .frame     (r_frame),
      .animSteps (AnimSteps),
      .width     (Width),
      .height    (Height),
      .address   (Address),
      .col       (w_col),
      .row       (w_row),
      .lastPixel (w_lastPixel),
      .empty     (w_empty)
   );

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state  <= c_IDLE;
         r_memSel <= '0;
         r_frame  <= '0;
         r_posX   <= '0;
         r_posY   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (Start) begin
                  r_state  <= c_SETUP;
                  r_memSel <= SpriteId;
                  r_frame  <= Frame;
                  r_posX   <= PosX;
                  r_posY   <= PosY;
               end
            end
            // An empty sprite still passes through DRAIN so that every draw
            // finishes W*H+3 cycles after its Start.
            c_SETUP: r_state <= w_empty ? c_DRAIN : c_RUN;
            c_RUN:   if (w_lastPixel) r_state <= c_DRAIN;
            c_DRAIN: r_state <= c_DONE;
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Pixel pipeline
   // ------------------------------------------------------------------------
   assign w_sumX = {1'b0, r_posX} + {{(XW-4){1'b0}}, r_col1};
   assign w_sumY = {1'b0, r_posY} + {{(YW-4){1'b0}}, r_row1};

   assign w_onScreen    = (w_sumX < c_SCREEN_W) && (w_sumY < c_SCREEN_H);
   assign w_transparent = c_KEY_EN && (DataOut == TRANSPARENT_COLOUR);

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_valid1 <= 1'b0;
         r_col1   <= '0;
         r_row1   <= '0;
         r_plotX  <= '0;
         r_plotY  <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
      end else begin
         // Every RUN cycle issues exactly one address.
         r_valid1 <= (r_state == c_RUN);
         r_col1   <= w_col;
         r_row1   <= w_row;

         if (r_valid1) begin
            // Coordinates and colour update even for clipped pixels.
            r_plotX  <= w_sumX[XW-1:0];
            r_plotY  <= w_sumY[YW-1:0];
            r_colour <= DataOut;
            r_plot   <= w_onScreen && !w_transparent;
         end else begin
            r_plot   <= 1'b0;
         end
      end
   end

   assign MemSel = r_memSel;
   assign PlotX  = r_plotX;
   assign PlotY  = r_plotY;
   assign Colour = r_colour;
   assign Plot   = r_plot;
   assign Busy   = (r_state != c_IDLE);
   assign Done   = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_blitter
//  Purpose  : Directed self-checking bench for sprite_blitter with a small
//             sprite memory model (word n holds colour n[8:0]).
//             Sprite table (by MemSel):
//               0: 16x16, AnimSteps 0      1: 16x16, AnimSteps 3
//               2: 0x16                    3: 3x2,   AnimSteps 0
//               4: 16x16, word 5 = 9'h1C7 (colour key)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Start;
   logic [2:0]  SpriteId;
   logic [2:0]  Frame;
   logic [7:0]  PosX;
   logic [6:0]  PosY;
   logic [2:0]  MemSel;
   logic [11:0] Address;
   logic [4:0]  Width;
   logic [4:0]  Height;
   logic [2:0]  AnimSteps;
   logic [8:0]  DataOut;
   logic [7:0]  PlotX;
   logic [6:0]  PlotY;
   logic [8:0]  Colour;
   logic        Plot;
   logic        Busy;
   logic        Done;

   int nChecks = 0;
   int nErrors = 0;

   // Results of the last runDraw
   int          nPlot;
   int          firstCyc;
   int          doneCyc;
   int          doneCount;
   logic        busy1;
   logic        busyAfter;
   logic [7:0]  firstX, lastX;
   logic [6:0]  firstY, lastY;
   logic [8:0]  firstC, lastC;
   logic [11:0] addrLog [0:299];

   always #5 Clock = ~Clock;

   sprite_blitter dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .Start     (Start),
      .SpriteId  (SpriteId),
      .Frame     (Frame),
      .PosX      (PosX),
      .PosY      (PosY),
      .MemSel    (MemSel),
      .Address   (Address),
      .Width     (Width),
      .Height    (Height),
      .AnimSteps (AnimSteps),
      .DataOut   (DataOut),
      .PlotX     (PlotX),
      .PlotY     (PlotY),
      .Colour    (Colour),
      .Plot      (Plot),
      .Busy      (Busy),
      .Done      (Done)
   );

   // Sprite memory model: geometry is combinational from MemSel, data is a
   // registered read of Address.
   always_comb begin
      Width     = 5'd16;
      Height    = 5'd16;
      AnimSteps = 3'd0;
      case (MemSel)
         3'd1:    AnimSteps = 3'd3;
         3'd2:    Width     = 5'd0;
         3'd3: begin
            Width  = 5'd3;
            Height = 5'd2;
         end
         default: ;
      endcase
   end

   always @(posedge Clock) begin
      if (MemSel == 3'd4 && Address == 12'd5) DataOut <= 9'h1C7;
      else                                    DataOut <= Address[8:0];
   end

   task automatic checkVal(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one draw and observes it until Done (bounded). Cycle 0 is the
   // cycle Start is high; outputs are sampled on falling edges.
   task automatic runDraw(input logic [2:0] spr, input logic [2:0] frm,
                          input logic [7:0] px, input logic [6:0] py,
                          input int extraStartCyc);
      int cyc;
      nPlot     = 0;
      firstCyc  = -1;
      doneCyc   = -1;
      doneCount = 0;
      busy1     = 1'b0;
      SpriteId  = spr;
      Frame     = frm;
      PosX      = px;
      PosY      = py;
      Start     = 1'b1;
      cyc       = 0;
      while (doneCyc < 0 && cyc < 400) begin
         @(negedge Clock);
         cyc++;
         if (cyc < 300) addrLog[cyc] = Address;
         if (cyc == 1) busy1 = Busy;
         if (Plot) begin
            if (nPlot == 0) begin
               firstCyc = cyc;
               firstX   = PlotX;
               firstY   = PlotY;
               firstC   = Colour;
            end
            lastX = PlotX;
            lastY = PlotY;
            lastC = Colour;
            nPlot++;
         end
         if (Done) begin
            doneCyc = cyc;
            doneCount++;
         end
         // A stray request while busy uses a different sprite.
         Start = (cyc == extraStartCyc);
         if (cyc == extraStartCyc) SpriteId = 3'd0;
      end
      Start = 1'b0;
      @(negedge Clock);
      busyAfter = Busy;
   endtask

   initial begin
      Resetn   = 1'b0;
      Start    = 1'b0;
      SpriteId = '0;
      Frame    = '0;
      PosX     = '0;
      PosY     = '0;
      repeat (3) @(negedge Clock);

      // Reset state
      checkVal("rst_plot",    Plot,    0);
      checkVal("rst_busy",    Busy,    0);
      checkVal("rst_done",    Done,    0);
      checkVal("rst_address", Address, 0);
      checkVal("rst_memsel",  MemSel,  0);
      checkVal("rst_plotx",   PlotX,   0);
      checkVal("rst_colour",  Colour,  0);
      Resetn = 1'b1;
      @(negedge Clock);

      // Basic 16x16 draw at (10,20)
      runDraw(3'd0, 3'd0, 8'd10, 7'd20, -1);
      checkVal("basic_busy1",     busy1,       1);
      checkVal("basic_nplot",     nPlot,       256);
      checkVal("basic_firstcyc",  firstCyc,    4);
      checkVal("basic_firstxyc",  {firstX, firstY, firstC}, {8'd10, 7'd20, 9'd0});
      checkVal("basic_lastxyc",   {lastX, lastY, lastC},    {8'd25, 7'd35, 9'd255});
      checkVal("basic_donecyc",   doneCyc,     259);
      checkVal("basic_busyafter", busyAfter,   0);

      // Animation frame 2 of 4: base 2*16*16
      runDraw(3'd1, 3'd2, 8'd0, 7'd0, -1);
      checkVal("anim_addr_first", addrLog[2],   512);
      checkVal("anim_addr_last",  addrLog[257], 767);
      checkVal("anim_nplot",      nPlot,        256);
      checkVal("anim_lastc",      lastC,        255);

      // Frame beyond AnimSteps falls back to frame 0
      runDraw(3'd0, 3'd2, 8'd0, 7'd0, -1);
      checkVal("animclamp_addr_first", addrLog[2], 0);

      // Clipping at the bottom-right corner
      runDraw(3'd0, 3'd0, 8'd150, 7'd115, -1);
      checkVal("clip_nplot",   nPlot,   50);
      checkVal("clip_donecyc", doneCyc, 259);
      checkVal("clip_firstxy", {firstX, firstY}, {8'd150, 7'd115});
      checkVal("clip_lastxyc", {lastX, lastY, lastC}, {8'd159, 7'd119, 9'd73});

      // Zero-width sprite
      runDraw(3'd2, 3'd0, 8'd5, 7'd5, -1);
      checkVal("empty_nplot",   nPlot,   0);
      checkVal("empty_donecyc", doneCyc, 3);

      // Small 3x2 sprite with a second Start while busy
      runDraw(3'd3, 3'd0, 8'd1, 7'd2, 4);
      checkVal("small_nplot",     nPlot,     6);
      checkVal("small_donecyc",   doneCyc,   9);
      checkVal("small_donecount", doneCount, 1);
      checkVal("small_lastxyc",   {lastX, lastY, lastC}, {8'd3, 7'd3, 9'd5});
      begin
         int busySeen = 0;
         repeat (5) begin
            @(negedge Clock);
            if (Busy) busySeen++;
         end
         checkVal("ignored_start_busy", busySeen, 0);
      end

      // Reset in the 100th RUN cycle (cycle 101)
      SpriteId = 3'd1;
      Frame    = 3'd1;
      PosX     = 8'd0;
      PosY     = 7'd0;
      Start    = 1'b1;
      for (int c = 1; c <= 101; c++) begin
         @(negedge Clock);
         Start = 1'b0;
      end
      checkVal("midrst_busy_before", Busy, 1);
      Resetn = 1'b0;
      @(negedge Clock);
      checkVal("midrst_plot",    Plot,    0);
      checkVal("midrst_busy",    Busy,    0);
      checkVal("midrst_memsel",  MemSel,  0);
      checkVal("midrst_address", Address, 0);
      Resetn = 1'b1;
      begin
         int dones = 0;
         repeat (300) begin
            @(negedge Clock);
            if (Done) dones++;
         end
         checkVal("midrst_no_done", dones, 0);
      end

      // Normal draw after the reset
      runDraw(3'd3, 3'd0, 8'd40, 7'd50, -1);
      checkVal("postrst_nplot",   nPlot,   6);
      checkVal("postrst_donecyc", doneCyc, 9);
      checkVal("postrst_firstxy", {firstX, firstY}, {8'd40, 7'd50});

      // Colour key sprite
      runDraw(3'd4, 3'd0, 8'd0, 7'd0, -1);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
      checkVal("key_nplot", nPlot, 255);
`else
      checkVal("key_nplot", nPlot, 256);
`endif
      checkVal("key_donecyc", doneCyc, 259);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
